mlp_axis_ingress: RTL and testbench
===================================

// Module: mlp_axis_ingress
// PURPOSE
//  AXI-Stream slave front end of the MLP accelerator. Accepts C_S_AXIS_TDATA_WIDTH-bit beats,
//  unpacks them into WIDTH-bit samples (lane 0 = LSBs first), buffers them in a DEPTH-entry FIFO
//  and presents one sample/cycle to the MLP core. Frame length is checked against cfg_frame_len.
// PARAMETERS
//  C_S_AXIS_TDATA_WIDTH  32  stream beat width; integer multiple of WIDTH
//  WIDTH                 16  sample width; multiple of 8
//  DEPTH                 16  FIFO depth in samples; power of 2, >= 2
//  FRAME_W               16  width of frame-length config and sample counter
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous reset, active-low
//  s_axis_tdata    in   TDATA_W    stream data
//  s_axis_tstrb    in   TDATA_W/8  byte strobes
//  s_axis_tvalid   in   1          beat valid
//  s_axis_tready   out  1          beat accepted when tvalid&tready
//  s_axis_tlast    in   1          last beat of frame
//  m_sample_data   out  WIDTH      sample to MLP core
//  m_sample_valid  out  1          sample valid
//  m_sample_ready  in   1          core accepts sample
//  m_sample_last   out  1          sample is last of its frame
//  cfg_frame_len   in   FRAME_W    expected samples/frame; 0 = check disabled
//  frame_done      out  1          1-cycle pulse when a last sample is popped
//  err_len         out  1          sticky: frame length mismatch
//  err_strb        out  1          sticky: lane with partial strobe
//  err_clr         in   1          clears both sticky errors
//  fifo_level      out  $clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  - Reset (rst=0 at posedge): tready=0 during reset, 1 first cycle after; m_sample_valid=0,
//    frame_done=0, err_*=0, fifo_level=0, hold reg empty, counters 0. FIFO memory not reset.
//  - LANES = TDATA_W/WIDTH. Lane valid iff all its WIDTH/8 strobes set; all-zero lane skipped
//    silently; mixed strobes: lane skipped, err_strb set.
//  - Unpacker FSM: IDLE (hold empty, tready=1) -> accept beat, latch data/lane mask/tlast -> UNPACK.
//    UNPACK writes lowest remaining valid lane to FIFO each cycle FIFO not full; stalls when full.
//    After last valid lane written: -> IDLE. tready=0 in UNPACK (no bubble-free overlap required).
//  - Beat with zero valid lanes: consumed in IDLE, no write, stays IDLE.
//  - Latency: beat accepted cycle N -> lane 0 in FIFO cycle N+1 -> m_sample_valid cycle N+2.
//  - FIFO: first-word fall-through; m_sample_valid = !empty; pop on valid&ready; push+pop same
//    cycle when full or empty both legal (level unchanged if both happen; empty push never bypasses).
//  - m_sample_last stored per entry: set on last valid lane of a tlast beat.
//  - Frame counter counts pushed samples, wraps at 2^FRAME_W. On write of a last sample:
//    if cfg_frame_len!=0 and count+1!=cfg_frame_len -> err_len; counter -> 0.
//    If count+1==cfg_frame_len on a non-last sample -> err_len, counter keeps counting.
//  - Zero-lane beat with tlast: err_len set (if cfg_frame_len!=0), counter -> 0, no last flag.
//  - err_clr and error set in same cycle: set wins.
//  - frame_done registered: high cycle after pop of a last sample.
//  - cfg_frame_len sampled continuously; change mid-frame is caller's responsibility.
// STRUCTURE
//  - Package mlp_axis_pkg: LANES, lane-valid function, FSM enum {IDLE, UNPACK}, level width.
//  - Sub-module mlp_sync_fifo (WIDTH+1 bits x DEPTH, FWFT, level output); rest in this file.
// TESTING
//  1 Reset: hold rst=0 3 cycles with tvalid=1 -> tready=0, valid=0, level=0, errs=0.
//  2 Beat 0x0002_0001, tstrb=F, tlast=1, cfg=2 -> samples 0x0001,0x0002 on cycles N+2,N+3,
//    last=1 on 2nd, frame_done next cycle, err_len=0.
//  3 tstrb=0x3, tlast=1, cfg=1 -> one sample 0x0001 last=1; tstrb=0x6 -> no samples, err_strb=1.
//  4 m_sample_ready=0, 10 full beats, DEPTH=16 -> level=16, tready low, no loss; release ->
//    20 samples in order, back-to-back.
//  5 cfg=4, frame of 3 samples with tlast -> err_len=1; err_clr pulse -> 0; err_clr coincident
//    with new mismatch -> stays 1.
//  6 rst=0 during UNPACK with level=5 -> level=0, valid=0 next cycle; fresh frame passes clean.

Source files
------------

// File: rtl/mlp_axis_pkg.sv
// Shared types and helpers for the MLP AXI-Stream ingress: unpacker states, lane/level sizing,
// and byte-strobe classification of one sample lane.
package mlp_axis_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } unp_state_e;

    function automatic int lanes(input int tdata_w, input int width);
        return tdata_w / width;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Returns {valid, bad}: valid = every strobe of the lane set, bad = some but not all set.
    function automatic logic [1:0] lane_class(input logic [63:0] strb, input int nbytes);
        logic all_set;
        logic any_set;
        all_set = 1'b1;
        any_set = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < nbytes) begin
                all_set = all_set & strb[i];
                any_set = any_set | strb[i];
            end
        end
        return {all_set, any_set & ~all_set};
    endfunction

endpackage

// File: rtl/mlp_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy output; push and pop in the
// same cycle are accepted whether the FIFO is full or empty.
module mlp_sync_fifo #(
    parameter int DW    = 17,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic          wr_en, rd_en;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rptr_q];

    // A pop frees the slot a concurrent push needs, so a full FIFO still takes the write.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mlp_axis_ingress.sv
// AXI-Stream slave front end of the MLP accelerator: unpacks beats into samples, buffers them
// in a FWFT FIFO, and checks frame length and byte strobes.
module mlp_axis_ingress
    import mlp_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int WIDTH                = 16,
    parameter int DEPTH                = 16,
    parameter int FRAME_W              = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [WIDTH-1:0]                  m_sample_data,
    output logic                              m_sample_valid,
    input  logic                              m_sample_ready,
    output logic                              m_sample_last,
    input  logic [FRAME_W-1:0]                cfg_frame_len,
    output logic                              frame_done,
    output logic                              err_len,
    output logic                              err_strb,
    input  logic                              err_clr,
    output logic [$clog2(DEPTH):0]            fifo_level
);
    localparam int TDW    = C_S_AXIS_TDATA_WIDTH;
    localparam int LANES  = lanes(TDW, WIDTH);
    localparam int BPL    = WIDTH / 8;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0] lane_ok, lane_bad;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] cls;
        assign cls         = lane_class(64'(s_axis_tstrb[l*BPL +: BPL]), BPL);
        assign lane_ok[l]  = cls[1];
        assign lane_bad[l] = cls[0];
    end

    unp_state_e       state_q, state_d;
    logic [TDW-1:0]   hold_data_q;
    logic [LANES-1:0] hold_mask_q, mask_d, rem_mask;
    logic             hold_last_q;
    logic             rdy_q;
    logic [LIDX_W-1:0] sel;
    logic             beat_acc, push, push_last, pop;
    logic             fifo_full, fifo_empty;
    logic [WIDTH-1:0] push_data;

    // rdy_q keeps tready low through reset and releases it the cycle after.
    assign s_axis_tready = rst && rdy_q && (state_q == IDLE);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        sel = '0;
        for (int l = LANES-1; l >= 0; l--) begin
            if (hold_mask_q[l]) sel = LIDX_W'(l);
        end
    end

    assign rem_mask  = hold_mask_q & ~(LANES'(1) << sel);
    assign push      = (state_q == UNPACK) && !fifo_full;
    assign push_data = hold_data_q[sel*WIDTH +: WIDTH];
    assign push_last = hold_last_q && (rem_mask == '0);

    always_comb begin
        state_d = state_q;
        mask_d  = hold_mask_q;
        case (state_q)
            IDLE: begin
                if (beat_acc && (lane_ok != '0)) state_d = UNPACK;
            end
            UNPACK: begin
                if (push) begin
                    mask_d = rem_mask;
                    if (rem_mask == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (beat_acc) hold_data_q <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_mask_q <= '0;
            hold_last_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (beat_acc) begin
                hold_mask_q <= lane_ok;
                hold_last_q <= s_axis_tlast;
            end else begin
                hold_mask_q <= mask_d;
            end
        end
    end

    logic [FRAME_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               len_set, strb_set, len_hit, zero_last;

    assign cnt_inc   = cnt_q + 1'b1;
    assign len_hit   = (cfg_frame_len != '0) && (cnt_inc == cfg_frame_len);
    assign zero_last = beat_acc && (lane_ok == '0) && s_axis_tlast;
    assign strb_set  = beat_acc && (lane_bad != '0);

    // Frame end must land exactly on cfg_frame_len; reaching it early is also an error.
    always_comb begin
        cnt_d   = cnt_q;
        len_set = 1'b0;
        if (push) begin
            if (push_last) begin
                len_set = (cfg_frame_len != '0) && !len_hit;
                cnt_d   = '0;
            end else begin
                len_set = len_hit;
                cnt_d   = cnt_inc;
            end
        end else if (zero_last) begin
            len_set = (cfg_frame_len != '0);
            cnt_d   = '0;
        end
    end

    assign pop = m_sample_valid && m_sample_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            err_len    <= 1'b0;
            err_strb   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            err_len    <= len_set  | (err_len  & ~err_clr);
            err_strb   <= strb_set | (err_strb & ~err_clr);
            frame_done <= pop && m_sample_last;
        end
    end

    mlp_sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_last, push_data}),
        .pop       (pop),
        .pop_data  ({m_sample_last, m_sample_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign m_sample_valid = !fifo_empty;

endmodule

// File: tb/tb_mlp_axis_ingress.sv
// Directed bench for mlp_axis_ingress: table of single-beat frames plus hand sequences for
// latency, backpressure, error stickiness and reset during unpacking.
module tb_mlp_axis_ingress;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic [15:0] sdata;
    logic        svalid;
    logic        sready = 1'b0;
    logic        slast;
    logic [15:0] cfg = '0;
    logic        frame_done;
    logic        err_len, err_strb;
    logic        err_clr = 1'b0;
    logic [4:0]  level;

    int total = 0;
    int bad   = 0;

    mlp_axis_ingress #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .WIDTH                (16),
        .DEPTH                (16),
        .FRAME_W              (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (tdata),
        .s_axis_tstrb   (tstrb),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tlast   (tlast),
        .m_sample_data  (sdata),
        .m_sample_valid (svalid),
        .m_sample_ready (sready),
        .m_sample_last  (slast),
        .cfg_frame_len  (cfg),
        .frame_done     (frame_done),
        .err_len        (err_len),
        .err_strb       (err_strb),
        .err_clr        (err_clr),
        .fifo_level     (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat until tready is seen, lets one edge accept it, then drops tvalid.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int t;
        t = 0;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        tvalid = 1'b1;
        while (!tready && t < 200) begin
            step();
            t++;
        end
        if (!tready) check("tready_timeout", 32'(tready), 32'd1);
        step();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic collect(output int got, output logic [15:0] d0, output logic [15:0] d1,
                           output logic last_flag);
        got = 0;
        d0 = '0;
        d1 = '0;
        last_flag = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (svalid) begin
                if (got == 0) d0 = sdata;
                if (got == 1) d1 = sdata;
                last_flag = slast;
                got++;
            end
            step();
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [15:0] cfg;
        int          n;
        logic [15:0] s0;
        logic [15:0] s1;
        logic        es;
        logic        el;
    } vec_t;

    vec_t vt [8];

    initial begin
        int          got, gaps;
        logic [15:0] d0, d1;
        logic        lf, acc;

        vt[0] = '{32'h0002_0001, 4'hF, 16'd2, 2, 16'h0001, 16'h0002, 1'b0, 1'b0};
        vt[1] = '{32'h0000_0001, 4'h3, 16'd1, 1, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vt[2] = '{32'hABCD_1234, 4'h6, 16'd0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{32'hBEEF_5555, 4'hC, 16'd1, 1, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        vt[4] = '{32'h1111_2222, 4'hF, 16'd3, 2, 16'h2222, 16'h1111, 1'b0, 1'b1};
        vt[5] = '{32'h0000_0001, 4'h0, 16'd2, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[6] = '{32'h7777_8888, 4'h7, 16'd1, 1, 16'h8888, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{32'hCAFE_0BAD, 4'hF, 16'd0, 2, 16'h0BAD, 16'hCAFE, 1'b0, 1'b0};

        // Reset held with a beat offered
        rst    = 1'b0;
        tvalid = 1'b1;
        tdata  = 32'h1234_5678;
        tstrb  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tready", 32'(tready), 32'd0);
        end
        check("rst_valid", 32'(svalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_err_strb", 32'(err_strb), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        tvalid = 1'b0;
        rst    = 1'b1;
        step();
        check("post_rst_tready", 32'(tready), 32'd1);

        // Latency: accept at N, valid at N+2, frame_done after the last pop
        sready = 1'b1;
        cfg    = 16'd2;
        send_beat(32'h0002_0001, 4'hF, 1'b1);
        check("lat_n1_valid", 32'(svalid), 32'd0);
        step();
        check("lat_n2_valid", 32'(svalid), 32'd1);
        check("lat_n2_data", 32'(sdata), 32'h0001);
        check("lat_n2_last", 32'(slast), 32'd0);
        step();
        check("lat_n3_data", 32'(sdata), 32'h0002);
        check("lat_n3_last", 32'(slast), 32'd1);
        check("lat_n3_done", 32'(frame_done), 32'd0);
        step();
        check("lat_n4_valid", 32'(svalid), 32'd0);
        check("lat_n4_done", 32'(frame_done), 32'd1);
        check("lat_err_len", 32'(err_len), 32'd0);
        step();
        check("lat_n5_done", 32'(frame_done), 32'd0);

        // Table of single-beat frames
        for (int v = 0; v < 8; v++) begin
            cfg = vt[v].cfg;
            send_beat(vt[v].data, vt[v].strb, 1'b1);
            collect(got, d0, d1, lf);
            check($sformatf("vec%0d_count", v), 32'(got), 32'(vt[v].n));
            if (vt[v].n > 0) begin
                check($sformatf("vec%0d_s0", v), 32'(d0), 32'(vt[v].s0));
                check($sformatf("vec%0d_last", v), 32'(lf), 32'd1);
            end
            if (vt[v].n > 1) check($sformatf("vec%0d_s1", v), 32'(d1), 32'(vt[v].s1));
            check($sformatf("vec%0d_err_strb", v), 32'(err_strb), 32'(vt[v].es));
            check($sformatf("vec%0d_err_len", v), 32'(err_len), 32'(vt[v].el));
            pulse_clr();
        end

        // Backpressure: fill the FIFO, hold a tenth beat, then drain 20 samples
        sready = 1'b0;
        cfg    = 16'd0;
        for (int i = 0; i < 9; i++)
            send_beat({16'(16'h0100 + 2*i + 1), 16'(16'h0100 + 2*i)}, 4'hF, 1'b0);
        tdata  = {16'h0113, 16'h0112};
        tstrb  = 4'hF;
        tlast  = 1'b1;
        tvalid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("bp_level_full", 32'(level), 32'd16);
        check("bp_tready_low", 32'(tready), 32'd0);
        check("bp_head", 32'(sdata), 32'h0100);
        sready = 1'b1;
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 100 && got < 20; c++) begin
            acc = tvalid && tready;
            if (svalid) begin
                check($sformatf("bp_data%0d", got), 32'(sdata), 32'(16'h0100 + got));
                check($sformatf("bp_last%0d", got), 32'(slast), 32'(got == 19));
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            step();
            if (acc) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
            end
        end
        check("bp_count", 32'(got), 32'd20);
        check("bp_gaps", 32'(gaps), 32'd0);
        check("bp_err_len", 32'(err_len), 32'd0);

        // Sticky length error, clear, and clear colliding with a new mismatch
        cfg = 16'd4;
        send_beat(32'h0002_0001, 4'hF, 1'b0);
        send_beat(32'h0000_0003, 4'h3, 1'b1);
        for (int i = 0; i < 6; i++) step();
        check("len_short_err", 32'(err_len), 32'd1);
        pulse_clr();
        check("len_cleared", 32'(err_len), 32'd0);
        send_beat(32'h0000_0005, 4'h3, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("len_set_wins", 32'(err_len), 32'd1);
        for (int i = 0; i < 4; i++) step();
        pulse_clr();
        check("len_cleared2", 32'(err_len), 32'd0);
        // Count reaching cfg on a non-last sample
        cfg = 16'd2;
        send_beat(32'h0002_0001, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("len_early_err", 32'(err_len), 32'd1);
        send_beat(32'h0000_0003, 4'h3, 1'b1);
        for (int i = 0; i < 4; i++) step();
        pulse_clr();
        check("err_strb_clean", 32'(err_strb), 32'd0);

        // Reset while unpacking with five samples queued
        sready = 1'b0;
        cfg    = 16'd0;
        send_beat(32'h0B0B_0A0A, 4'hF, 1'b0);
        send_beat(32'h0D0D_0C0C, 4'hF, 1'b0);
        send_beat(32'h0F0F_0E0E, 4'hF, 1'b0);
        step();
        check("pre_rst_level", 32'(level), 32'd5);
        rst = 1'b0;
        step();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(svalid), 32'd0);
        check("mid_rst_tready", 32'(tready), 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_tready_back", 32'(tready), 32'd1);
        sready = 1'b1;
        cfg    = 16'd2;
        send_beat(32'h0002_0001, 4'hF, 1'b1);
        collect(got, d0, d1, lf);
        check("fresh_count", 32'(got), 32'd2);
        check("fresh_s0", 32'(d0), 32'h0001);
        check("fresh_s1", 32'(d1), 32'h0002);
        check("fresh_last", 32'(lf), 32'd1);
        check("fresh_err_len", 32'(err_len), 32'd0);
        check("fresh_err_strb", 32'(err_strb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
